fifo_wr_arbiter: RTL

Round-robin, burst-locked arbiter that shares the single write port of a `cdcfifo` instance between `NUM_REQ` requesters in the write-clock domain. It grants one requester at a time for up to `MAX_BURST` beats. Accepted beats are registered into a one-entry output stage that drives `writeValid`/`writeData` into the FIFO and honours `writeReady` back-pressure.

---
 rtl/fifo_wr_arbiter_if.sv | 38 +++
 rtl/fifo_wr_arbiter.sv | 126 ++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bus between the requesters, the arbiter and the FIFO write port.
// The arbiter takes the slave view; requesters and FIFO together take the master view.
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_WIDTH = 8,
    parameter int ID_W       = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]            reqValid;
    logic [NUM_REQ*FIFO_WIDTH-1:0] reqData;
    logic [NUM_REQ-1:0]            reqReady;
    logic                          writeValid;
    logic [FIFO_WIDTH-1:0]         writeData;
    logic                          writeReady;
    logic                          grantValid;
    logic [ID_W-1:0]               grantId;

    modport slave (
        input  reqValid,
        input  reqData,
        input  writeReady,
        output reqReady,
        output writeValid,
        output writeData,
        output grantValid,
        output grantId
    );

    modport master (
        output reqValid,
        output reqData,
        output writeReady,
        input  reqReady,
        input  writeValid,
        input  writeData,
        input  grantValid,
        input  grantId
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locked arbiter sharing one FIFO write port between NUM_REQ
// requesters, with a one-entry registered output stage honouring writeReady.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic            wrclk,
    input  logic            rst,
    fifo_wr_arbiter_if.slave bus
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [IDW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]        grant_id_q, grant_id_d;
    logic [CW-1:0]         burst_cnt_q, burst_cnt_d;
    logic                  write_valid_q, write_valid_d;
    logic [FIFO_WIDTH-1:0] write_data_q, write_data_d;

    logic                  any_req;
    logic [IDW-1:0]        winner;
    logic [FIFO_WIDTH-1:0] sel_data;
    logic                  out_ready;
    logic                  accept;
    logic [NUM_REQ-1:0]    req_ready;
    logic [IDW-1:0]        next_ptr;

    // Scan downwards so the index closest to rr_ptr_q is the last (winning) assignment.
    always_comb begin
        any_req = 1'b0;
        winner  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (bus.reqValid[IDW'((int'(rr_ptr_q) + k) % NUM_REQ)]) begin
                any_req = 1'b1;
                winner  = IDW'((int'(rr_ptr_q) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id_q == IDW'(i)) begin
                sel_data = bus.reqData[i*FIFO_WIDTH +: FIFO_WIDTH];
            end
        end
    end

    assign out_ready = !write_valid_q || bus.writeReady;
    assign next_ptr  = (grant_id_q == IDW'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        grant_id_d    = grant_id_q;
        burst_cnt_d   = burst_cnt_q;
        write_valid_d = write_valid_q;
        write_data_d  = write_data_q;
        req_ready     = '0;
        accept        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_id_d  = winner;
                    burst_cnt_d = '0;
                    state_d     = BURST;
                end
            end
            BURST: begin
                req_ready[grant_id_q] = out_ready;
                accept = bus.reqValid[grant_id_q] && out_ready;
                if (!bus.reqValid[grant_id_q]) begin
                    state_d  = IDLE;
                    rr_ptr_d = next_ptr;
                end else if (accept) begin
                    burst_cnt_d = burst_cnt_q + 1'b1;
                    if (burst_cnt_q == CW'(MAX_BURST - 1)) begin
                        state_d  = IDLE;
                        rr_ptr_d = next_ptr;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A freshly accepted beat always refills the stage, even while it drains.
        if (accept) begin
            write_valid_d = 1'b1;
            write_data_d  = sel_data;
        end else if (write_valid_q && bus.writeReady) begin
            write_valid_d = 1'b0;
        end
    end

    always_ff @(posedge wrclk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            grant_id_q    <= '0;
            burst_cnt_q   <= '0;
            write_valid_q <= 1'b0;
            write_data_q  <= '0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            grant_id_q    <= grant_id_d;
            burst_cnt_q   <= burst_cnt_d;
            write_valid_q <= write_valid_d;
            write_data_q  <= write_data_d;
        end
    end

    assign bus.reqReady   = req_ready;
    assign bus.writeValid = write_valid_q;
    assign bus.writeData  = write_data_q;
    assign bus.grantValid = (state_q == BURST);
    assign bus.grantId    = grant_id_q;
endmodule
